// File: rtl/button_conditioner.sv
// Front-panel button conditioner: per-button synchronizer, debouncer, edge pulses,
// long-press detection and auto-repeat, all on the system clock.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int REP_W  = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEATING
  } hold_state_e;

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;
  logic [N_BTN-1:0] press_vec_d;
  logic             any_press_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      any_press_q <= 1'b0;
    end else begin
      s1_q        <= btn_raw;
      s2_q        <= s1_q;
      any_press_q <= |press_vec_d;
    end
  end

  assign any_press = any_press_q;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
      hold_state_e       state_q, state_d;
      logic              stable_q, stable_d;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              long_q, long_d;
      logic              repeat_q, repeat_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          db_cnt_q   <= '0;
          hold_cnt_q <= '0;
          rep_cnt_q  <= '0;
          state_q    <= ST_IDLE;
          stable_q   <= 1'b0;
          press_q    <= 1'b0;
          release_q  <= 1'b0;
          long_q     <= 1'b0;
          repeat_q   <= 1'b0;
        end else begin
          db_cnt_q   <= db_cnt_d;
          hold_cnt_q <= hold_cnt_d;
          rep_cnt_q  <= rep_cnt_d;
          state_q    <= state_d;
          stable_q   <= stable_d;
          press_q    <= press_d;
          release_q  <= release_d;
          long_q     <= long_d;
          repeat_q   <= repeat_d;
        end
      end

      always_comb begin
        db_cnt_d   = '0;
        stable_d   = stable_q;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        // Any sample equal to the accepted level restarts the debounce window.
        if (s2_q[gi] != stable_q) begin
          if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = s2_q[gi];
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end

        press_d   = stable_d & ~stable_q;
        release_d = ~stable_d & stable_q;

        if (release_d) begin
          // Release wins over any long/repeat pulse due on the same cycle.
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (press_d) begin
                state_d    = ST_HELD;
                hold_cnt_d = '0;
                repeat_d   = 1'b1;
              end
            end
            ST_HELD: begin
              if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                long_d    = 1'b1;
                repeat_d  = 1'b1;
                state_d   = ST_REPEATING;
                rep_cnt_d = '0;
              end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
              end
            end
            ST_REPEATING: begin
              if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
                repeat_d  = 1'b1;
                rep_cnt_d = '0;
              end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      assign press_vec_d[gi] = press_d;
      assign btn_level[gi]   = stable_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
      assign btn_long[gi]    = long_q;
      assign btn_repeat[gi]  = repeat_q;
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat limits.
module tb_button_conditioner;

  localparam int N = 5;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;
  logic         any_press;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat), .any_press(any_press)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Event log filled by watch(): counts and first-occurrence cycle numbers.
  int press_n, rel_n, long_n, rep_n, anyp_n, lvl_n;
  int press_t, rel_t, long_t, anyp_t;
  int rep_t[$];
  logic [N-1:0] other_act, press_vec;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic watch(input int b, input int n);
    press_n = 0; rel_n = 0; long_n = 0; rep_n = 0; anyp_n = 0; lvl_n = 0;
    press_t = -1; rel_t = -1; long_t = -1; anyp_t = -1;
    rep_t.delete();
    other_act = '0; press_vec = '0;
    for (int j = 1; j <= n; j++) begin
      tick();
      if (btn_level[b]) lvl_n++;
      if (btn_press[b]) begin press_n++; if (press_t < 0) press_t = j; end
      if (btn_release[b]) begin rel_n++; if (rel_t < 0) rel_t = j; end
      if (btn_long[b]) begin long_n++; if (long_t < 0) long_t = j; end
      if (btn_repeat[b]) begin rep_n++; rep_t.push_back(j); end
      if (any_press) begin
        anyp_n++;
        if (anyp_t < 0) begin anyp_t = j; press_vec = btn_press; end
      end
      other_act |= (btn_level | btn_press | btn_release | btn_long | btn_repeat) & ~(N'(1) << b);
    end
  endtask

  task automatic test_reset();
    logic [5*N:0] outs;
    rst = 1'b1;
    btn_raw = '1;
    tick(); tick(); tick();
    outs = {btn_level, btn_press, btn_release, btn_long, btn_repeat, any_press};
    total_cnt++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs); else pass_cnt++;
    btn_raw = '0;
    rst = 1'b0;
    watch(0, 8);
    total_cnt++;
    if (other_act !== '0 || lvl_n != 0) $display("FAIL reset_quiet: other=%b lvl=%0d expected 0/0", other_act, lvl_n);
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    btn_raw[0] = 1'b1;
    watch(0, 10);
    total_cnt++;
    if (press_t !== 6) $display("FAIL clean_press_time: got %0d expected 6", press_t); else pass_cnt++;
    total_cnt++;
    if (press_n !== 1) $display("FAIL clean_press_count: got %0d expected 1", press_n); else pass_cnt++;
    total_cnt++;
    if (rep_n !== 1 || rep_t[0] !== 6) $display("FAIL clean_first_repeat: got n=%0d expected n=1 at 6", rep_n); else pass_cnt++;
    total_cnt++;
    if (anyp_t !== 6 || anyp_n !== 1) $display("FAIL clean_any_press: got t=%0d n=%0d expected 6/1", anyp_t, anyp_n); else pass_cnt++;
    total_cnt++;
    if (lvl_n !== 5) $display("FAIL clean_level_cycles: got %0d expected 5", lvl_n); else pass_cnt++;
    total_cnt++;
    if (other_act !== '0) $display("FAIL clean_other_bits: got %b expected 0", other_act); else pass_cnt++;
    btn_raw[0] = 1'b0;
    watch(0, 12);
    total_cnt++;
    if (rel_t !== 6 || rel_n !== 1) $display("FAIL clean_release: got t=%0d n=%0d expected 6/1", rel_t, rel_n); else pass_cnt++;
    total_cnt++;
    if (rep_n !== 0 || long_n !== 0 || btn_level[0] !== 1'b0)
      $display("FAIL clean_after_release: got rep=%0d long=%0d lvl=%b expected 0/0/0", rep_n, long_n, btn_level[0]);
    else pass_cnt++;
    $display("test_clean_press done");
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    int bsum;
    pat = 4'b1010;
    bsum = 0;
    for (int i = 0; i < 4; i++) begin
      btn_raw[2] = pat[3-i];
      watch(2, 1);
      bsum += lvl_n + press_n + rel_n + rep_n;
    end
    btn_raw[2] = 1'b1;
    watch(2, 10);
    total_cnt++;
    if (bsum !== 0) $display("FAIL bounce_quiet: got %0d events expected 0", bsum); else pass_cnt++;
    total_cnt++;
    if (press_t !== 6 || press_n !== 1) $display("FAIL bounce_press: got t=%0d n=%0d expected 6/1", press_t, press_n); else pass_cnt++;
    btn_raw[2] = 1'b0;
    watch(2, 12);
    $display("test_bounce done");
  endtask

  task automatic test_glitch();
    int early;
    btn_raw[1] = 1'b1;
    watch(1, 3);
    early = lvl_n + press_n + rep_n;
    btn_raw[1] = 1'b0;
    watch(1, 10);
    total_cnt++;
    if (early + lvl_n + press_n + rel_n + rep_n !== 0)
      $display("FAIL glitch_rejected: got %0d events expected 0", early + lvl_n + press_n + rel_n + rep_n);
    else pass_cnt++;
    // Four samples is the shortest pulse that must be accepted.
    btn_raw[1] = 1'b1;
    watch(1, 4);
    btn_raw[1] = 1'b0;
    watch(1, 10);
    total_cnt++;
    if (press_t !== 2 || rel_t !== 6) $display("FAIL min_pulse_edges: got press=%0d rel=%0d expected 2/6", press_t, rel_t); else pass_cnt++;
    total_cnt++;
    if (lvl_n !== 4) $display("FAIL min_pulse_level: got %0d expected 4", lvl_n); else pass_cnt++;
    $display("test_glitch done");
  endtask

  task automatic test_long_repeat();
    int exp_rep[7] = '{6, 26, 34, 42, 50, 58, 66};
    btn_raw[4] = 1'b1;
    watch(4, 68);
    total_cnt++;
    if (press_t !== 6) $display("FAIL long_press_time: got %0d expected 6", press_t); else pass_cnt++;
    total_cnt++;
    if (long_n !== 1 || long_t !== 26) $display("FAIL long_event: got n=%0d t=%0d expected 1/26", long_n, long_t); else pass_cnt++;
    total_cnt++;
    if (rep_n !== 7) $display("FAIL repeat_count: got %0d expected 7", rep_n); else pass_cnt++;
    for (int i = 0; i < 7 && i < rep_n; i++) begin
      total_cnt++;
      if (rep_t[i] !== exp_rep[i]) $display("FAIL repeat_time_%0d: got %0d expected %0d", i, rep_t[i], exp_rep[i]);
      else pass_cnt++;
    end
    // Release lands on the cycle a repeat would otherwise fire.
    btn_raw[4] = 1'b0;
    watch(4, 12);
    total_cnt++;
    if (rel_t !== 6 || rel_n !== 1) $display("FAIL long_release: got t=%0d n=%0d expected 6/1", rel_t, rel_n); else pass_cnt++;
    total_cnt++;
    if (rep_n !== 0 || long_n !== 0) $display("FAIL release_suppress: got rep=%0d long=%0d expected 0/0", rep_n, long_n); else pass_cnt++;
    $display("test_long_repeat done");
  endtask

  task automatic test_chord();
    btn_raw[0] = 1'b1;
    btn_raw[3] = 1'b1;
    watch(0, 10);
    total_cnt++;
    if (press_vec !== 5'b01001) $display("FAIL chord_press_vec: got %b expected 01001", press_vec); else pass_cnt++;
    total_cnt++;
    if (anyp_n !== 1 || anyp_t !== 6) $display("FAIL chord_any_press: got n=%0d t=%0d expected 1/6", anyp_n, anyp_t); else pass_cnt++;
    btn_raw[0] = 1'b0;
    btn_raw[3] = 1'b0;
    watch(3, 12);
    total_cnt++;
    if (rel_t !== 6 || btn_release !== '0) $display("FAIL chord_release: got t=%0d expected 6", rel_t); else pass_cnt++;
    $display("test_chord done");
  endtask

  task automatic test_reset_mid_hold();
    logic [5*N:0] outs;
    btn_raw[4] = 1'b1;
    watch(4, 30);
    total_cnt++;
    if (long_n !== 1) $display("FAIL midhold_reached_long: got %0d expected 1", long_n); else pass_cnt++;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      outs = {btn_level, btn_press, btn_release, btn_long, btn_repeat, any_press};
      total_cnt++;
      if (outs !== '0) $display("FAIL midhold_reset_out_%0d: got %h expected 0", i, outs); else pass_cnt++;
    end
    rst = 1'b0;
    watch(4, 10);
    total_cnt++;
    if (press_t !== 6 || press_n !== 1) $display("FAIL midhold_repress: got t=%0d n=%0d expected 6/1", press_t, press_n); else pass_cnt++;
    total_cnt++;
    if (rel_n !== 0) $display("FAIL midhold_no_release: got %0d expected 0", rel_n); else pass_cnt++;
    btn_raw[4] = 1'b0;
    watch(4, 12);
    $display("test_reset_mid_hold done");
  endtask

  initial begin
    rst = 1'b1;
    btn_raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_long_repeat();
    test_chord();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side counterpart to the display/sound output path: turns the five raw, bouncing front-panel buttons (up, down, left, right, middle) into clean levels and single-cycle events.
- Its events are consumed by mode selection, alarm setting and time setting.
- Per button, the block provides:
  - a 2-flop synchronizer;
  - a counter-based debouncer;
  - press/release edge pulses;
  - long-press detection;
  - auto-repeat while held.
- Runs on the main system clock; it has no dependency on the divided clocks.

Parameters:
- N_BTN, 5, number of buttons. Bit order is {middle, right, left, down, up}, so bit 0 = up.
- DEBOUNCE_CYCLES, 1000000, number of consecutive synchronized cycles a new level must hold before it is accepted. Must be ≥ 1.
- HOLD_CYCLES, 50000000, cycles of accepted-pressed state before the long-press event fires. Must be ≥ 2.
- REPEAT_CYCLES, 10000000, period of repeat pulses after the long-press point. Must be ≥ 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  asynchronous raw button levels, 1 = pressed.
- btn_level  output  N_BTN  debounced level, 1 = pressed.
- btn_press  output  N_BTN  1-cycle pulse when the debounced level goes 0→1.
- btn_release  output  N_BTN  1-cycle pulse when the debounced level goes 1→0.
- btn_long  output  N_BTN  1-cycle pulse, once per press, when HOLD_CYCLES is reached.
- btn_repeat  output  N_BTN  1-cycle pulses while the button is held: on press, at HOLD_CYCLES, then every REPEAT_CYCLES.
- any_press  output  1  OR of btn_press.

Behaviour:
- Reset
  - While rst=1 at an edge, all of the following clear to 0: synchronizer flops, debounce counters, stable levels, hold counters, repeat counters, and all outputs.
  - Reset has priority over every other event.
- Synchronizer
  - s1 <= btn_raw; s2 <= s1.
  - The debouncer sees only s2.
- Debouncer (independent per button)
  - If s2 == stable, the counter clears to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, stable <= s2 and the counter clears.
  - Any bounce back to the stable value clears the counter; partial counts never accumulate across bounces.
- Latency
  - Let edge k be the first edge at which raw=1 is sampled into s1.
  - stable flips at edge k+1+DEBOUNCE_CYCLES.
  - btn_press is high for exactly the one cycle after that edge.
  - Release follows the same timing.
- Edge pulses
  - press = stable_next & ~stable; release = ~stable_next & stable.
  - Both are registered alongside stable, so btn_level and the pulse rise together.
- Hold/repeat state machine (per button)
  - States: IDLE, HELD, REPEATING.
  - IDLE → HELD on the press pulse. btn_repeat pulses together with btn_press, so the first step is immediate. hold_cnt clears to 0.
  - In HELD, hold_cnt increments each cycle. When hold_cnt reaches HOLD_CYCLES-1, btn_long and btn_repeat pulse on the next cycle, the state becomes REPEATING, and rep_cnt clears.
  - In REPEATING, rep_cnt increments. When it reaches REPEAT_CYCLES-1, btn_repeat pulses, rep_cnt wraps to 0, and the state stays REPEATING.
  - Release from any state → IDLE in the same edge as the release pulse. Any long/repeat pulse that would land on that same cycle is suppressed.
  - btn_long fires at most once per press.
- Counters
  - Widths are $clog2 of their limits (minimum 1 bit).
  - No counter may overflow; hold_cnt stops counting once in REPEATING.
- Simultaneous buttons
  - Buttons are fully independent.
  - Chords produce same-cycle pulses on multiple bits; no priority or masking is applied.
- Reset mid-press
  - All outputs drop to 0 immediately after the reset edge.
  - A button still held after reset is re-detected as a fresh press after the normal latency. No release pulse is generated for the aborted press.
- Outputs are registered; there are no combinational paths from btn_raw.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8):
- Clean press: raw[0] 0→1 at edge 10 and held → btn_level[0]=1 and btn_press[0]=btn_repeat[0]=any_press=1 for one cycle after edge 15. No other bits toggle.
- Bounce: raw[2] toggles 1,0,1,0,1 on successive edges, then stays 1 → no pulse during the bounce. A single btn_press[2] occurs 6 edges after the last 0→1 transition.
- Glitch rejection: raw[1] high for 3 cycles, then low → btn_level[1] stays 0 and no pulses occur.
- Long press and repeat: hold raw[4] for 60 cycles after acceptance →
  - press+repeat at t0;
  - long+repeat at t0+20;
  - repeat at t0+28, t0+36, t0+44, t0+52;
  - on release after debounce: one btn_release[4] and no further repeats;
  - exactly one btn_long in total.
- Chord: raw[0] and raw[3] rise on the same edge → btn_press[0] and btn_press[3] both pulse in the same cycle, and any_press pulses once.
- Reset mid-hold: button accepted and in REPEATING, assert rst for 2 cycles while raw stays 1 → all outputs 0 with no release pulse. A new btn_press fires 6 edges after rst deasserts.
